// File: rtl/delay_timer_mc.sv
// Multi-channel programmable delay/period timer.
// Every channel counts from 0 up to its active period. When the count
// equals the period the channel fires a one-cycle pulse on sig and raises
// pend. A fire that arrives while pend is still set raises the sticky err flag.
// A new period written through the config port is held in a shadow register.
// It reaches the running counter only on the next start or fire.
module delay_timer_mc #(
   parameter int CHANNELS  = 4,
   parameter int CBITS     = 14,
   parameter int DEFAULT_N = 12500,
   localparam int CHW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cfg_we,
   input  logic [CHW-1:0]      cfg_ch,
   input  logic [CBITS-1:0]    cfg_period,
   input  logic                cfg_periodic,
   input  logic [CHANNELS-1:0] start,
   input  logic [CHANNELS-1:0] stop,
   input  logic [CHANNELS-1:0] ack,
   input  logic [CHANNELS-1:0] err_clr,
   output logic [CHANNELS-1:0] sig,
   output logic [CHANNELS-1:0] pend,
   output logic [CHANNELS-1:0] busy,
   output logic [CHANNELS-1:0] err
);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t              r_state    [CHANNELS];
   state_t              w_stateNext[CHANNELS];
   logic [CBITS-1:0]    r_cnt      [CHANNELS];
   logic [CBITS-1:0]    w_cntNext  [CHANNELS];
   logic [CBITS-1:0]    r_pa       [CHANNELS];
   logic [CBITS-1:0]    w_paNext   [CHANNELS];
   logic [CBITS-1:0]    r_ps       [CHANNELS];
   logic [CBITS-1:0]    w_psNext   [CHANNELS];
   logic [CHANNELS-1:0] r_mode;
   logic [CHANNELS-1:0] w_modeNext;
   logic [CHANNELS-1:0] w_fire;
   logic [CHANNELS-1:0] r_sig;
   logic [CHANNELS-1:0] r_pend;
   logic [CHANNELS-1:0] w_pendNext;
   logic [CHANNELS-1:0] r_err;
   logic [CHANNELS-1:0] w_errNext;
   logic [CHANNELS-1:0] r_busy;
   logic [CHANNELS-1:0] w_busyNext;

   // State register: all per-channel state, cleared to reset values asynchronously
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int c = 0; c < CHANNELS; c++) begin
            r_state[c] <= IDLE;
            r_cnt[c]   <= '0;
            r_pa[c]    <= CBITS'(DEFAULT_N);
            r_ps[c]    <= CBITS'(DEFAULT_N);
         end
         r_mode <= '0;
         r_sig  <= '0;
         r_pend <= '0;
         r_err  <= '0;
         r_busy <= '0;
      end else begin
         for (int c = 0; c < CHANNELS; c++) begin
            r_state[c] <= w_stateNext[c];
            r_cnt[c]   <= w_cntNext[c];
            r_pa[c]    <= w_paNext[c];
            r_ps[c]    <= w_psNext[c];
         end
         r_mode <= w_modeNext;
         r_sig  <= w_fire;
         r_pend <= w_pendNext;
         r_err  <= w_errNext;
         r_busy <= w_busyNext;
      end
   end

   // Next state per channel: a same-edge config write is visible to start and fire; stop beats start beats counting
   always_comb begin
      for (int c = 0; c < CHANNELS; c++) begin
         w_psNext[c]    = r_ps[c];
         w_modeNext[c]  = r_mode[c];
         w_stateNext[c] = r_state[c];
         w_cntNext[c]   = r_cnt[c];
         w_paNext[c]    = r_pa[c];
         w_fire[c]      = 1'b0;
         if (cfg_we && (cfg_ch == CHW'(c))) begin
            w_psNext[c]   = cfg_period;
            w_modeNext[c] = cfg_periodic;
         end
         if (stop[c]) begin
            w_stateNext[c] = IDLE;
            w_cntNext[c]   = '0;
         end else if (start[c]) begin
            w_stateNext[c] = RUN;
            w_cntNext[c]   = '0;
            w_paNext[c]    = w_psNext[c];
         end else if (r_state[c] == RUN) begin
            if (r_cnt[c] == r_pa[c]) begin
               w_fire[c]      = 1'b1;
               w_cntNext[c]   = '0;
               w_paNext[c]    = w_psNext[c];
               w_stateNext[c] = w_modeNext[c] ? RUN : IDLE;
            end else begin
               w_cntNext[c] = r_cnt[c] + CBITS'(1);
            end
         end
      end
   end

   // Output flags: a new fire outranks ack on pend, and a new overrun outranks err_clr on err
   always_comb begin
      for (int c = 0; c < CHANNELS; c++) begin
         w_pendNext[c] = r_pend[c];
         w_errNext[c]  = r_err[c];
         w_busyNext[c] = (w_stateNext[c] == RUN);
         if (w_fire[c]) begin
            w_pendNext[c] = 1'b1;
         end else if (ack[c]) begin
            w_pendNext[c] = 1'b0;
         end
         if (w_fire[c] && r_pend[c] && !ack[c]) begin
            w_errNext[c] = 1'b1;
         end else if (err_clr[c]) begin
            w_errNext[c] = 1'b0;
         end
      end
   end

   assign sig  = r_sig;
   assign pend = r_pend;
   assign busy = r_busy;
   assign err  = r_err;

endmodule

// File: tb/tb_delay_timer_mc.sv
// Bench for delay_timer_mc.
// Each cycle's stimulus is fed through a countdown model of the timer.
// The model's expected outputs are queued, and a monitor process compares them with the DUT outputs.
module tb_delay_timer_mc;

   localparam int CH = 4;
   localparam int CB = 14;
   localparam int DN = 12500;

   logic          clk;
   logic          rst;
   logic          cfgWe;
   logic [1:0]    cfgCh;
   logic [CB-1:0] cfgPeriod;
   logic          cfgPeriodic;
   logic [CH-1:0] startV;
   logic [CH-1:0] stopV;
   logic [CH-1:0] ackV;
   logic [CH-1:0] errClrV;
   logic [CH-1:0] sigV;
   logic [CH-1:0] pendV;
   logic [CH-1:0] busyV;
   logic [CH-1:0] errV;

   typedef struct {
      logic [CH-1:0] sig;
      logic [CH-1:0] pend;
      logic [CH-1:0] busy;
      logic [CH-1:0] err;
      int            cyc;
   } expT;

   expT q[$];
   int  checks = 0;
   int  errors = 0;
   int  cycle  = 0;

   // Reference model: remaining counting edges before the next fire, plus shadow settings and flags
   int mLeft [CH];
   bit mRun  [CH];
   int mPs   [CH];
   bit mMode [CH];
   bit mPend [CH];
   bit mErr  [CH];

   delay_timer_mc #(.CHANNELS(CH), .CBITS(CB), .DEFAULT_N(DN)) dut (
      .clk(clk), .rst(rst),
      .cfg_we(cfgWe), .cfg_ch(cfgCh), .cfg_period(cfgPeriod), .cfg_periodic(cfgPeriodic),
      .start(startV), .stop(stopV), .ack(ackV), .err_clr(errClrV),
      .sig(sigV), .pend(pendV), .busy(busyV), .err(errV)
   );

   // Free-running 10-time-unit clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic resetModel();
      for (int c = 0; c < CH; c++) begin
         mLeft[c] = 0;
         mRun[c]  = 1'b0;
         mPs[c]   = DN;
         mMode[c] = 1'b0;
         mPend[c] = 1'b0;
         mErr[c]  = 1'b0;
      end
   endtask

   task automatic stepModel(input logic we, input int sel, input int per, input logic md,
                            input logic [CH-1:0] st, input logic [CH-1:0] sp,
                            input logic [CH-1:0] ak, input logic [CH-1:0] ec, output expT e);
      e.sig = '0; e.pend = '0; e.busy = '0; e.err = '0; e.cyc = cycle;
      for (int c = 0; c < CH; c++) begin
         int psE;
         bit mdE;
         bit fire;
         psE  = mPs[c];
         mdE  = mMode[c];
         fire = 1'b0;
         if (we && sel == c) begin
            psE = per;
            mdE = md;
         end
         if (sp[c]) begin
            mRun[c] = 1'b0;
         end else if (st[c]) begin
            mRun[c]  = 1'b1;
            mLeft[c] = psE;
         end else if (mRun[c]) begin
            if (mLeft[c] == 0) begin
               fire     = 1'b1;
               mLeft[c] = psE;
               mRun[c]  = mdE;
            end else begin
               mLeft[c] = mLeft[c] - 1;
            end
         end
         if (fire && mPend[c] && !ak[c]) mErr[c] = 1'b1;
         else if (ec[c])                  mErr[c] = 1'b0;
         if (fire)       mPend[c] = 1'b1;
         else if (ak[c]) mPend[c] = 1'b0;
         mPs[c]   = psE;
         mMode[c] = mdE;
         e.sig[c]  = fire;
         e.pend[c] = mPend[c];
         e.busy[c] = mRun[c];
         e.err[c]  = mErr[c];
      end
   endtask

   // Drive one cycle of inputs at the falling edge, queue the model's prediction, and return just after the rising edge
   task automatic applyStimulus(input logic we, input int sel, input int per, input logic md,
                                input logic [CH-1:0] st, input logic [CH-1:0] sp,
                                input logic [CH-1:0] ak, input logic [CH-1:0] ec);
      expT e;
      @(negedge clk);
      cfgWe       = we;
      cfgCh       = 2'(sel);
      cfgPeriod   = CB'(per);
      cfgPeriodic = md;
      startV      = st;
      stopV       = sp;
      ackV        = ak;
      errClrV     = ec;
      stepModel(we, sel, per, md, st, sp, ak, ec, e);
      q.push_back(e);
      cycle++;
      @(posedge clk);
      #2;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, 0, 1'b0, '0, '0, '0, '0);
   endtask

   // Monitor: every rising edge, one expected entry is compared with the registered outputs
   initial begin
      expT e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            checkOutput($sformatf("sig@%0d", e.cyc),  32'(sigV),  32'(e.sig));
            checkOutput($sformatf("pend@%0d", e.cyc), 32'(pendV), 32'(e.pend));
            checkOutput($sformatf("busy@%0d", e.cyc), 32'(busyV), 32'(e.busy));
            checkOutput($sformatf("err@%0d", e.cyc),  32'(errV),  32'(e.err));
         end
      end
   end

   // Directed scenarios, a randomized phase, and async reset
   initial begin
      rst = 1'b1; cfgWe = 1'b0; cfgCh = '0; cfgPeriod = '0; cfgPeriodic = 1'b0;
      startV = '0; stopV = '0; ackV = '0; errClrV = '0;
      resetModel();
      #1;
      checkOutput("reset_sig",  32'(sigV),  32'h0);
      checkOutput("reset_pend", 32'(pendV), 32'h0);
      checkOutput("reset_busy", 32'(busyV), 32'h0);
      checkOutput("reset_err",  32'(errV),  32'h0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Default one-shot on ch0: fires 12501 cycles after start
      $display("[TB] default one-shot latency");
      applyStimulus(1'b0, 0, 0, 1'b0, 4'b0001, '0, '0, '0);
      idle(DN);
      checkOutput("oneshot_before_fire", 32'(sigV[0]), 32'h0);
      idle(1);
      checkOutput("oneshot_fire_sig",  32'(sigV[0]),  32'h1);
      checkOutput("oneshot_fire_busy", 32'(busyV[0]), 32'h0);
      checkOutput("oneshot_fire_pend", 32'(pendV[0]), 32'h1);
      applyStimulus(1'b0, 0, 0, 1'b0, '0, '0, 4'b0001, '0);

      // Periodic ch1 with P=3, acked each fire, then left unacked
      $display("[TB] periodic ch1");
      applyStimulus(1'b1, 1, 3, 1'b1, '0, '0, '0, '0);
      applyStimulus(1'b0, 0, 0, 1'b0, 4'b0010, '0, '0, '0);
      for (int i = 0; i < 20; i++)
         applyStimulus(1'b0, 0, 0, 1'b0, '0, '0, {2'b00, mPend[1], 1'b0}, '0);
      checkOutput("periodic_acked_err", 32'(errV[1]), 32'h0);
      idle(9);
      checkOutput("periodic_overrun_err", 32'(errV[1]), 32'h1);
      applyStimulus(1'b0, 0, 0, 1'b0, '0, 4'b0010, 4'b0010, 4'b0010);
      idle(1);
      checkOutput("periodic_err_cleared", 32'(errV[1]), 32'h0);

      // Shadow period on ch2: P=5 running, P=2 written mid-count
      $display("[TB] shadow period ch2");
      applyStimulus(1'b1, 2, 5, 1'b1, 4'b0100, '0, '0, '0);
      idle(2);
      applyStimulus(1'b1, 2, 2, 1'b1, '0, '0, '0, '0);
      idle(14);
      applyStimulus(1'b0, 0, 0, 1'b0, '0, 4'b0100, 4'b0100, 4'b0100);

      // Priority on ch3: stop+start at cnt==Pa, then restart at cnt=2
      $display("[TB] priority ch3");
      applyStimulus(1'b1, 3, 4, 1'b1, 4'b1000, '0, '0, '0);
      idle(4);
      applyStimulus(1'b0, 0, 0, 1'b0, 4'b1000, 4'b1000, '0, '0);
      checkOutput("prio_no_sig",  32'(sigV[3]),  32'h0);
      checkOutput("prio_idle",    32'(busyV[3]), 32'h0);
      applyStimulus(1'b0, 0, 0, 1'b0, 4'b1000, '0, '0, '0);
      idle(2);
      applyStimulus(1'b0, 0, 0, 1'b0, 4'b1000, '0, '0, '0);
      idle(4);
      checkOutput("restart_no_early_sig", 32'(sigV[3]), 32'h0);
      idle(1);
      checkOutput("restart_sig", 32'(sigV[3]), 32'h1);
      applyStimulus(1'b0, 0, 0, 1'b0, '0, 4'b1000, 4'b1000, 4'b1000);

      // P=0 periodic on ch0: continuous sig, overrun on the second fire
      $display("[TB] zero period ch0");
      applyStimulus(1'b1, 0, 0, 1'b1, 4'b0001, '0, '0, '0);
      idle(1);
      checkOutput("p0_first_sig", 32'(sigV[0]), 32'h1);
      checkOutput("p0_first_err", 32'(errV[0]), 32'h0);
      idle(1);
      checkOutput("p0_second_sig", 32'(sigV[0]), 32'h1);
      checkOutput("p0_second_err", 32'(errV[0]), 32'h1);
      idle(4);
      applyStimulus(1'b0, 0, 0, 1'b0, '0, 4'b0001, 4'b0001, 4'b0001);

      // Randomized traffic over all channels with small periods
      $display("[TB] random phase");
      for (int i = 0; i < 3000; i++) begin
         logic [CH-1:0] st, sp, ak, ec;
         for (int c = 0; c < CH; c++) begin
            st[c] = ($urandom_range(15) == 0);
            sp[c] = ($urandom_range(31) == 0);
            ak[c] = ($urandom_range(3) == 0);
            ec[c] = ($urandom_range(15) == 0);
         end
         applyStimulus(($urandom_range(7) == 0), int'($urandom_range(3)), int'($urandom_range(11)),
                       logic'($urandom_range(1)), st, sp, ak, ec);
      end

      // Async reset in the middle of a run on every channel
      $display("[TB] async reset mid-run");
      applyStimulus(1'b1, 0, 9, 1'b1, 4'b1111, '0, '0, '0);
      idle(5);
      #1;
      rst = 1'b1;
      #1;
      checkOutput("async_rst_sig",  32'(sigV),  32'h0);
      checkOutput("async_rst_pend", 32'(pendV), 32'h0);
      checkOutput("async_rst_busy", 32'(busyV), 32'h0);
      checkOutput("async_rst_err",  32'(errV),  32'h0);
      resetModel();
      cfgWe = 1'b0; startV = '0; stopV = '0; ackV = '0; errClrV = '0;
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(1'b0, 0, 0, 1'b0, 4'b0001, '0, '0, '0);
      idle(DN);
      checkOutput("post_rst_before_fire", 32'(sigV[0]), 32'h0);
      idle(1);
      checkOutput("post_rst_default_fire", 32'(sigV[0]), 32'h1);

      checkOutput("queue_drained", 32'(q.size()), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
